// File: rtl/prefix_addsub_pkg.sv
// Shared types and constants for the pipelined Sklansky prefix adder/subtractor.
package prefix_addsub_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBB = 2'b11;

    // Group generate/propagate pair carried through the prefix tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Register stages: one operand stage plus one per LVL_PER_STG prefix levels.
    function automatic int unsigned stage_count(input int unsigned width,
                                                input int unsigned lvl_per_stg);
        int unsigned levels;
        levels = 32'($clog2(width));
        return 1 + (levels + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

endpackage

// File: rtl/prefix_gp_cell.sv
// Sklansky black cell: merges a high (G,P) group with the adjacent lower group.
module prefix_gp_cell
    import prefix_addsub_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o.g = hi.g | (hi.p & lo.g);
    assign o.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Sklansky adder/subtractor with valid/ready flow control and
// per-stage bubble collapse; a tag rides along with each operand beat.
module prefix_addsub_pipe
    import prefix_addsub_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned LVL_PER_STG = 2,
    parameter int unsigned TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned L    = 32'($clog2(WIDTH));
    localparam int unsigned S    = stage_count(WIDTH, LVL_PER_STG);
    localparam int unsigned LAST = L - 1;

    logic [S-1:0] v;
    logic [S-1:0] adv;

    // A stage may load if it, or any stage downstream of it, is empty or
    // the consumer drains this cycle.
    for (genvar k = 0; k < S; k++) begin : g_adv
        assign adv[k] = out_ready || !(&v[S-1:k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            v <= (adv & {v[S-2:0], in_valid}) | (~adv & v);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[S-1];

    // Operand conditioning: invert b for subtraction, pick the carry-in.
    logic [WIDTH-1:0] b_x;
    logic             c0;

    always_comb begin
        b_x = in_b;
        c0  = 1'b0;
        if (in_op[1]) begin
            b_x = ~in_b;
        end
        unique case (in_op)
            OP_ADD:  c0 = 1'b0;
            OP_ADC:  c0 = in_cin;
            OP_SUB:  c0 = 1'b1;
            OP_SBB:  c0 = ~in_cin;
            default: c0 = 1'b0;
        endcase
    end

    logic [WIDTH-1:0] s0_p;
    logic [WIDTH-1:0] s0_g;
    logic             s0_c0;
    logic [TAG_W-1:0] s0_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_p   <= '0;
            s0_g   <= '0;
            s0_c0  <= 1'b0;
            s0_tag <= '0;
        end else if (adv[0]) begin
            s0_p   <= in_a ^ b_x;
            s0_g   <= in_a & b_x;
            s0_c0  <= c0;
            s0_tag <= in_tag;
        end
    end

    // One generate block per prefix level; a register closes each group of
    // LVL_PER_STG levels, and the final level always ends in a register.
    for (genvar l = 0; l < L; l++) begin : lvl
        localparam bit          REG = (((l + 1) % LVL_PER_STG) == 0) || (l == LAST);
        localparam int unsigned K   = 32'(1 + l / LVL_PER_STG);

        gp_t [WIDTH-1:0]  gp_in;
        gp_t [WIDTH-1:0]  gp_c;
        gp_t [WIDTH-1:0]  gp_q;
        logic [WIDTH-1:0] sp_in;
        logic [WIDTH-1:0] sp_q;
        logic             c0_in;
        logic             c0_q;
        logic [TAG_W-1:0] tag_in;
        logic [TAG_W-1:0] tag_q;

        if (l == 0) begin : g_src
            // Carry-in folded into bit 0 as the generate of position -1.
            assign gp_in[0] = '{g: s0_g[0] | (s0_p[0] & s0_c0), p: 1'b0};
            for (genvar i = 1; i < WIDTH; i++) begin : g_bit
                assign gp_in[i] = '{g: s0_g[i], p: s0_p[i]};
            end
            assign sp_in  = s0_p;
            assign c0_in  = s0_c0;
            assign tag_in = s0_tag;
        end else begin : g_src
            assign gp_in  = lvl[l-1].gp_q;
            assign sp_in  = lvl[l-1].sp_q;
            assign c0_in  = lvl[l-1].c0_q;
            assign tag_in = lvl[l-1].tag_q;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_col
            if (((i >> l) & 1) == 1) begin : g_blk
                prefix_gp_cell u_cell (
                    .hi (gp_in[i]),
                    .lo (gp_in[((i >> (l + 1)) << (l + 1)) + (1 << l) - 1]),
                    .o  (gp_c[i])
                );
            end else begin : g_pass
                assign gp_c[i] = gp_in[i];
            end
        end

        if (REG) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    gp_q  <= '0;
                    sp_q  <= '0;
                    c0_q  <= 1'b0;
                    tag_q <= '0;
                end else if (adv[K]) begin
                    gp_q  <= gp_c;
                    sp_q  <= sp_in;
                    c0_q  <= c0_in;
                    tag_q <= tag_in;
                end
            end
        end else begin : g_wire
            assign gp_q  = gp_c;
            assign sp_q  = sp_in;
            assign c0_q  = c0_in;
            assign tag_q = tag_in;
        end
    end

    // g_fin[i] is the group generate over [i:-1], i.e. the carry into bit i+1.
    logic [WIDTH-1:0] g_fin;
    logic [WIDTH-1:0] p_fin;
    logic             unused_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fin_bit
        assign g_fin[i] = lvl[LAST].gp_q[i].g;
        assign p_fin[i] = lvl[LAST].gp_q[i].p;
    end

    assign unused_p = ^p_fin;

    assign out_sum  = lvl[LAST].sp_q ^ {g_fin[WIDTH-2:0], lvl[LAST].c0_q};
    assign out_cout = g_fin[WIDTH-1];
    assign out_ovf  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
    assign out_zero = out_valid && (out_sum == '0);
    assign out_tag  = lvl[LAST].tag_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Bench for prefix_addsub_pipe (WIDTH=16, LVL_PER_STG=2): directed vectors,
// backpressure, mid-flight reset and a random stream against an arithmetic model.
module tb_prefix_addsub_pipe;
    import prefix_addsub_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [1:0]    in_op;
    logic          in_cin;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic          out_zero;
    logic [TW-1:0] out_tag;

    prefix_addsub_pipe #(.WIDTH(W), .LVL_PER_STG(2), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    vec_t        vecs [12];
    logic [22:0] sb [$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_consumed = 0;
    bit          hold_prev = 1'b0;
    logic [22:0] hold_val = '0;
    bit          last_in_ready = 1'b0;
    bit          acc;
    bit          saw_block;
    int          lat;
    int          idx;
    int          cyc;
    int          stale;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin,
                                          input logic [TW-1:0] tag);
        logic [W:0]   r;
        logic [W-1:0] bb;
        logic         c;
        logic         ovf;
        bb = op[1] ? ~b : b;
        case (op)
            OP_ADD:  c = 1'b0;
            OP_ADC:  c = cin;
            OP_SUB:  c = 1'b1;
            default: c = ~cin;
        endcase
        r   = {1'b0, a} + {1'b0, bb} + 17'(c);
        ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return {tag, r[W-1:0] == '0, ovf, r[W], r[W-1:0]};
    endfunction

    // One clock: sample at negedge+1, check ready/hold/result, advance to next negedge.
    task automatic step(output bit accepted);
        logic [22:0] cur;
        logic [22:0] e;
        #1;
        cur = {out_tag, out_zero, out_ovf, out_cout, out_sum};
        last_in_ready = in_ready;
        if (!rst) check("in_ready", 64'(in_ready), 64'(out_ready || (sb.size() < 3)));
        if (hold_prev) check("hold_stable", 64'({out_valid, cur}), 64'({1'b1, hold_val}));
        accepted = in_valid && in_ready && !rst;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                check("result", 64'(cur), 64'(e));
                n_consumed++;
            end
        end
        hold_prev = out_valid && !out_ready;
        hold_val  = cur;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{OP_SUB, 16'h0069, 16'h0069, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{OP_SBB, 16'h0000, 16'h0001, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{OP_ADC, 16'h55AA, 16'hAA55, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_ADC, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_SUB, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{OP_SBB, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{OP_SBB, 16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = OP_ADD; in_cin = 1'b0; in_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_state", 64'({out_valid, in_ready, out_tag, out_zero, out_ovf, out_cout, out_sum}),
              64'({1'b0, 1'b1, 23'h0}));
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, one at a time, with latency measured per beat.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b;
            in_cin = vecs[i].cin; in_tag = 4'(i);
            step(acc);
            if (acc) sb.push_back({4'(i), vecs[i].zero, vecs[i].ovf, vecs[i].cout, vecs[i].sum});
            else check("vec_accept", 64'(last_in_ready), 64'(1));
            in_valid = 1'b0;
            lat = 0;
            while (sb.size() > 0 && lat < 20) begin
                lat++;
                step(acc);
            end
            check("vec_latency", 64'(lat), 64'(3));
        end

        // Eight back-to-back beats with a five-cycle consumer stall mid-stream.
        idx = 0; cyc = 0; n_consumed = 0; saw_block = 1'b0;
        while ((idx < 8 || sb.size() > 0) && cyc < 60) begin
            out_ready = !(cyc >= 3 && cyc < 8);
            in_valid  = (idx < 8);
            in_op = OP_ADD; in_a = 16'(idx * 16'h1111); in_b = 16'h0F0F; in_cin = 1'b0;
            in_tag = 4'(idx);
            step(acc);
            if (!last_in_ready) saw_block = 1'b1;
            if (acc) begin
                sb.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
                idx++;
            end
            cyc++;
        end
        check("bp_delivered", 64'(n_consumed), 64'(8));
        check("bp_in_ready_drop", 64'(saw_block), 64'(1));
        in_valid = 1'b0;

        // Fill all three stages, then reset while a new beat is presented.
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1; in_op = OP_SUB; in_a = 16'(16'h0100 + j); in_b = 16'h0001;
            in_cin = 1'b0; in_tag = 4'(8 + j);
            step(acc);
            if (acc) sb.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
        end
        check("fill_blocked", 64'(in_ready), 64'(0));
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_tag = 4'hF;
        step(acc);
        sb.delete();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("post_reset", 64'({out_valid, in_ready, out_tag, out_zero, out_ovf, out_cout, out_sum}),
              64'({1'b0, 1'b1, 23'h0}));
        out_ready = 1'b1;
        stale = 0;
        for (int j = 0; j < 10; j++) begin
            step(acc);
            if (out_valid) stale++;
        end
        check("no_stale", 64'(stale), 64'(0));

        // Random ops under random in_valid / out_ready.
        for (int j = 0; j < 400; j++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op  = 2'($urandom_range(0, 3));
            in_a   = 16'($urandom);
            in_b   = 16'($urandom);
            in_cin = 1'($urandom_range(0, 1));
            in_tag = 4'($urandom_range(0, 15));
            step(acc);
            if (acc) sb.push_back(model(in_op, in_a, in_b, in_cin, in_tag));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (sb.size() > 0 && cyc < 20) begin
            step(acc);
            cyc++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
